// File: rtl/router_switch_arb.sv
// Wormhole-style switch allocator: each output arbitrates round-robin among the
// inputs addressing it and stays locked to the winner until that packet's tail.
module router_switch_arb #(
    parameter  int NUM_IN  = 3,
    parameter  int NUM_OUT = 4,
    parameter  int DST_W   = 2,
    localparam int IDX_W   = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_IN-1:0]          req_valid,
    input  logic [NUM_IN*DST_W-1:0]    req_dst,
    input  logic [NUM_IN-1:0]          req_last,
    input  logic [NUM_OUT-1:0]         out_ready,
    output logic [NUM_IN-1:0]          in_ready,
    output logic [NUM_OUT-1:0]         out_valid,
    output logic [NUM_OUT*IDX_W-1:0]   out_sel,
    output logic [NUM_IN-1:0]          fail,
    output logic [NUM_IN-1:0]          err_dst
);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    logic [NUM_OUT-1:0]             state_q, state_d;
    logic [NUM_OUT-1:0][IDX_W-1:0]  owner_q, owner_d;
    logic [NUM_OUT-1:0][IDX_W-1:0]  ptr_q, ptr_d;
    logic [NUM_IN-1:0]              fail_q, fail_d;
    logic [NUM_IN-1:0]              err_dst_q, err_dst_d;

    logic [NUM_IN-1:0]               legal;
    logic [NUM_OUT-1:0][NUM_IN-1:0]  req_match;
    logic [NUM_OUT-1:0]              grant_vld;
    logic [NUM_OUT-1:0][IDX_W-1:0]   grant_idx;
    logic [NUM_IN-1:0]               in_grant;

    // Out-of-range destinations match no output, so they can never be granted.
    always_comb begin
        legal     = '0;
        req_match = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            legal[i] = int'(req_dst[i*DST_W +: DST_W]) < NUM_OUT;
            for (int o = 0; o < NUM_OUT; o++) begin
                req_match[o][i] = req_valid[i] && legal[i] &&
                                  (int'(req_dst[i*DST_W +: DST_W]) == o);
            end
        end
    end

    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = '0;
        grant_idx = '0;
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        for (int o = 0; o < NUM_OUT; o++) begin
            if (state_q[o] == ST_IDLE) begin
                if (out_ready[o]) begin
                    for (int k = 0; k < NUM_IN; k++) begin
                        idx = (int'(ptr_q[o]) + k) % NUM_IN;
                        if (!grant_vld[o] && req_match[o][idx]) begin
                            grant_vld[o] = 1'b1;
                            grant_idx[o] = IDX_W'(idx);
                        end
                    end
                end
            end else if (out_ready[o] && req_match[o][owner_q[o]]) begin
                grant_vld[o] = 1'b1;
                grant_idx[o] = owner_q[o];
            end

            if (grant_vld[o]) begin
                if (state_q[o] == ST_IDLE) begin
                    ptr_d[o] = IDX_W'((int'(grant_idx[o]) + 1) % NUM_IN);
                    if (!req_last[grant_idx[o]]) begin
                        state_d[o] = ST_LOCKED;
                        owner_d[o] = grant_idx[o];
                    end
                end else if (req_last[grant_idx[o]]) begin
                    state_d[o] = ST_IDLE;
                end
            end
        end
    end

    // An input has one destination, so at most one output can grant it.
    always_comb begin
        in_grant = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            if (grant_vld[o]) in_grant[grant_idx[o]] = 1'b1;
        end
    end

    always_comb begin
        in_ready  = rst_n ? '0 : in_grant;
        out_valid = rst_n ? '0 : grant_vld;
        out_sel   = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            if (!rst_n && grant_vld[o]) out_sel[o*IDX_W +: IDX_W] = grant_idx[o];
        end
    end

    always_comb begin
        fail_d    = req_valid & legal & ~in_grant;
        err_dst_d = err_dst_q | (req_valid & ~legal);
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            fail_q    <= '0;
            err_dst_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            fail_q    <= fail_d;
            err_dst_q <= err_dst_d;
        end
    end

    assign fail    = fail_q;
    assign err_dst = err_dst_q;

endmodule

// File: tb/tb_router_switch_arb.sv
// Directed bench for router_switch_arb: default instance plus a NUM_OUT=3
// instance for the illegal-destination case.
module tb_router_switch_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req_valid;
    logic [5:0] req_dst;
    logic [2:0] req_last;
    logic [3:0] out_ready;

    logic [2:0] in_ready, fail, err_dst;
    logic [3:0] out_valid;
    logic [7:0] out_sel;

    logic [2:0] in_ready3, fail3, err_dst3, out_valid3;
    logic [5:0] out_sel3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    router_switch_arb u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_dst   (req_dst),
        .req_last  (req_last),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .fail      (fail),
        .err_dst   (err_dst)
    );

    router_switch_arb #(.NUM_OUT(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_dst   (req_dst),
        .req_last  (req_last),
        .out_ready (out_ready[2:0]),
        .in_ready  (in_ready3),
        .out_valid (out_valid3),
        .out_sel   (out_sel3),
        .fail      (fail3),
        .err_dst   (err_dst3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input logic [1:0] d2, input logic [1:0] d1,
                         input logic [1:0] d0, input logic [2:0] l, input logic [3:0] r);
        req_valid = v;
        req_dst   = {d2, d1, d0};
        req_last  = l;
        out_ready = r;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        drive(3'b000, 2'd0, 2'd0, 2'd0, 3'b000, 4'b1111);
        tick();
        tick();
        rst_n = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(3'b111, 2'd1, 2'd1, 2'd1, 3'b111, 4'b1111);
        check("rst_in_ready", in_ready, 3'b000);
        check("rst_out_valid", out_valid, 4'b0000);
        check("rst_out_sel", out_sel, 8'h00);
        check("rst_fail", fail, 3'b000);
        check("rst_err_dst", err_dst, 3'b000);
        do_reset();

        // Three single-flit requesters on output 1: round-robin 0,1,2.
        tick(); drive(3'b111, 2'd1, 2'd1, 2'd1, 3'b111, 4'b1111);
        check("rr_c0_in_ready", in_ready, 3'b001);
        check("rr_c0_out_valid", out_valid, 4'b0010);
        check("rr_c0_out_sel", out_sel, 8'h00);
        tick(); drive(3'b111, 2'd1, 2'd1, 2'd1, 3'b111, 4'b1111);
        check("rr_c1_in_ready", in_ready, 3'b010);
        check("rr_c1_out_sel", out_sel, 8'h04);
        check("rr_c1_fail", fail, 3'b110);
        tick(); drive(3'b111, 2'd1, 2'd1, 2'd1, 3'b111, 4'b1111);
        check("rr_c2_in_ready", in_ready, 3'b100);
        check("rr_c2_out_sel", out_sel, 8'h08);
        check("rr_c2_fail", fail, 3'b101);
        tick(); drive(3'b000, 2'd0, 2'd0, 2'd0, 3'b000, 4'b1111);
        check("rr_c3_fail", fail, 3'b011);
        check("rr_err_dst", err_dst, 3'b000);

        // Input 1 holds output 2 for a 3-flit packet; input 0 waits.
        do_reset();
        tick(); drive(3'b010, 2'd0, 2'd2, 2'd0, 3'b000, 4'b1111);
        check("lk_c0_in_ready", in_ready, 3'b010);
        tick(); drive(3'b011, 2'd0, 2'd2, 2'd2, 3'b000, 4'b1111);
        check("lk_c1_in_ready", in_ready, 3'b010);
        check("lk_c1_out_sel", out_sel, 8'h10);
        tick(); drive(3'b011, 2'd0, 2'd2, 2'd2, 3'b010, 4'b1111);
        check("lk_c2_in_ready", in_ready, 3'b010);
        check("lk_c2_fail", fail, 3'b001);
        tick(); drive(3'b001, 2'd0, 2'd0, 2'd2, 3'b001, 4'b1111);
        check("lk_c3_in_ready", in_ready, 3'b001);
        check("lk_c3_out_sel", out_sel, 8'h00);
        check("lk_c3_out_valid", out_valid, 4'b0100);
        check("lk_c3_fail", fail, 3'b001);
        tick(); drive(3'b000, 2'd0, 2'd0, 2'd0, 3'b000, 4'b1111);
        check("lk_c4_fail", fail, 3'b000);

        // Parallel grants on independent outputs, then output 3 stalled.
        do_reset();
        tick(); drive(3'b101, 2'd3, 2'd0, 2'd0, 3'b111, 4'b1001);
        check("par_in_ready", in_ready, 3'b101);
        check("par_out_valid", out_valid, 4'b1001);
        check("par_out_sel", out_sel, 8'h80);
        tick(); drive(3'b101, 2'd3, 2'd0, 2'd0, 3'b111, 4'b0001);
        check("par_stall_in_ready", in_ready, 3'b001);
        tick(); drive(3'b000, 2'd0, 2'd0, 2'd0, 3'b000, 4'b1111);
        check("par_stall_fail", fail, 3'b100);

        // Owner 2 locks output 1, which then backpressures for 4 cycles.
        do_reset();
        tick(); drive(3'b100, 2'd1, 2'd0, 2'd0, 3'b000, 4'b1111);
        check("bp_grant", in_ready, 3'b100);
        for (int c = 0; c < 4; c++) begin
            tick(); drive(3'b101, 2'd1, 2'd0, 2'd1, 3'b000, 4'b1101);
            check($sformatf("bp_stall%0d_in_ready", c), in_ready, 3'b000);
            check($sformatf("bp_stall%0d_out_valid", c), out_valid, 4'b0000);
        end
        tick(); drive(3'b001, 2'd1, 2'd0, 2'd1, 3'b000, 4'b1111);
        check("bp_owner_idle_in_ready", in_ready, 3'b000);
        tick(); drive(3'b101, 2'd1, 2'd0, 2'd1, 3'b100, 4'b1111);
        check("bp_resume_in_ready", in_ready, 3'b100);
        check("bp_resume_out_sel", out_sel, 8'h08);
        tick(); drive(3'b001, 2'd0, 2'd0, 2'd1, 3'b001, 4'b1111);
        check("bp_after_tail_in_ready", in_ready, 3'b001);

        // Destination 3 is illegal when NUM_OUT=3.
        do_reset();
        tick(); drive(3'b010, 2'd0, 2'd3, 2'd0, 3'b111, 4'b1111);
        check("ill_in_ready", in_ready3, 3'b000);
        check("ill_err_pre", err_dst3, 3'b000);
        tick(); drive(3'b000, 2'd0, 2'd0, 2'd0, 3'b000, 4'b1111);
        check("ill_err_set", err_dst3, 3'b010);
        check("ill_fail", fail3, 3'b000);
        tick(); tick();
        check("ill_err_sticky", err_dst3, 3'b010);

        // Asynchronous reset mid-packet drops the lock without a clock edge.
        do_reset();
        tick(); drive(3'b010, 2'd0, 2'd0, 2'd0, 3'b000, 4'b1111);
        check("ar_grant", in_ready, 3'b010);
        tick(); drive(3'b011, 2'd0, 2'd0, 2'd0, 3'b000, 4'b1111);
        check("ar_pre_in_ready", in_ready, 3'b010);
        check("ar_pre_fail", fail, 3'b000);
        tick(); drive(3'b011, 2'd0, 2'd0, 2'd0, 3'b000, 4'b1111);
        check("ar_pre2_fail", fail, 3'b001);
        rst_n = 1'b1;
        #1;
        check("ar_async_in_ready", in_ready, 3'b000);
        check("ar_async_out_valid", out_valid, 4'b0000);
        check("ar_async_fail", fail, 3'b000);
        tick();
        rst_n = 1'b0;
        tick(); drive(3'b111, 2'd0, 2'd0, 2'd0, 3'b111, 4'b1111);
        check("ar_restart_in_ready", in_ready, 3'b001);
        check("ar_restart_out_sel", out_sel, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/router_switch_arb.md
ROUTER_SWITCH_ARB -- requirements
Module: router_switch_arb

Interface
REQ-001 SHALL have parameter NUM_IN, default 3, number of input ports (legal 2..8).
REQ-002 SHALL have parameter NUM_OUT, default 4, number of output ports (legal 2..2**DST_W).
REQ-003 SHALL have parameter DST_W, default 2, destination field width per input.
REQ-004 SHALL derive IDX_W = max(1, clog2(NUM_IN)) for input-index fields.
REQ-005 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset: asynchronous, active-high (rst_n=1 resets).
REQ-007 SHALL have port req_valid, input, NUM_IN, input i presents a flit.
REQ-008 SHALL have port req_dst, input, NUM_IN*DST_W, destination of input i in bits [i*DST_W +: DST_W].
REQ-009 SHALL have port req_last, input, NUM_IN, flit of input i is the packet tail.
REQ-010 SHALL have port out_ready, input, NUM_OUT, output port o can accept a flit.
REQ-011 SHALL have port in_ready, output, NUM_IN, flit of input i transfers this cycle (combinational).
REQ-012 SHALL have port out_valid, output, NUM_OUT, output o carries a flit this cycle (combinational).
REQ-013 SHALL have port out_sel, output, NUM_OUT*IDX_W, input index driving output o in [o*IDX_W +: IDX_W]; 0 when out_valid[o]=0.
REQ-014 SHALL have port fail, output, NUM_IN, registered: input i was valid with a legal destination and did not transfer in the previous cycle.
REQ-015 SHALL have port err_dst, output, NUM_IN, sticky: input i presented req_valid with req_dst >= NUM_OUT.

Function
REQ-016 SHALL keep per output o: state {IDLE, LOCKED}, owner[IDX_W], rr pointer ptr[IDX_W].
REQ-017 SHALL treat input i as requesting o when req_valid[i]=1 and req_dst[i]==o; requests with req_dst >= NUM_OUT SHALL never be granted.
REQ-018 In IDLE with out_ready[o]=1, SHALL grant the first requesting input searching ptr, ptr+1, ... NUM_IN-1, 0, ... (wrap-around).
REQ-019 In IDLE with out_ready[o]=0, SHALL grant nothing and leave state, owner, ptr unchanged.
REQ-020 On an IDLE grant to input g with req_last[g]=0, SHALL go LOCKED, owner=g, ptr=(g+1) mod NUM_IN at the next edge.
REQ-021 On an IDLE grant to input g with req_last[g]=1 (single-flit packet), SHALL stay IDLE and set ptr=(g+1) mod NUM_IN.
REQ-022 In LOCKED, SHALL grant only owner, and only when owner requests o and out_ready[o]=1; other requesters to o SHALL be refused.
REQ-023 In LOCKED, owner transfer with req_last=1 SHALL return to IDLE at the next edge; ptr unchanged.
REQ-024 In LOCKED, owner deasserting req_valid or redirecting req_dst SHALL keep the lock (no timeout).
REQ-025 SHALL assert in_ready[i] exactly when input i is granted by its destination output; at most one grant per output and per input per cycle.
REQ-026 SHALL set out_valid[o]=in_ready[g] and out_sel[o]=g for the granted input g.
REQ-027 SHALL register fail[i] = req_valid[i] & legal dst & ~in_ready[i] every cycle.
REQ-028 SHALL set err_dst[i] on the edge after an illegal request and hold it until reset.
REQ-029 SHALL have zero-cycle grant latency: the granted flit transfers in the same cycle its request is seen.

Reset
REQ-030 While rst_n=1, SHALL force all outputs' state=IDLE, owner=0, ptr=0, fail=0, err_dst=0 immediately, independent of clk.
REQ-031 Reset asserted mid-packet SHALL drop all locks; first cycle after release SHALL arbitrate from ptr=0.
REQ-032 Combinational outputs during reset SHALL be in_ready=0, out_valid=0, out_sel=0.

Verification
REQ-033 Defaults; inputs 0,1,2 all valid, dst=1, last=1, out_ready=all 1, for 3 cycles -> grants 0,1,2 in order; fail=3'b110 then 3'b101.
REQ-034 Input 1 sends 3-flit packet to dst 2 (last on 3rd); input 0 requests dst 2 from cycle 2 -> input 0 refused during lock, fail[0]=1, granted in cycle after input 1's tail.
REQ-035 Input 0 dst 0 and input 2 dst 3, both valid, out_ready=4'b1001 -> both in_ready=1 same cycle, out_sel[0]=0, out_sel[3]=2.
REQ-036 Locked owner input 2 on dst 1, out_ready[1]=0 for 4 cycles -> no transfer, lock held, owner resumes when out_ready[1]=1.
REQ-037 NUM_OUT=3, input 1 req_dst=3 -> never granted, err_dst[1]=1 next edge and sticky; fail[1]=0.
REQ-038 rst_n pulsed high mid-packet asynchronously -> in_ready drops without clk edge; after release, arbitration restarts at input 0.
